// File: rtl/matpow_pkg.sv
// Shared definitions for the matrix-power recurrence engine.
package matpow_pkg;

  localparam int unsigned W_DEF  = 32;
  localparam int unsigned NW_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOOP = 1'b1
  } state_e;

  // Entry (row, col) of the 2x2 identity matrix; caller widens to W.
  function automatic logic ident_bit(input logic row, input logic col);
    return (row == col);
  endfunction

endpackage

// File: rtl/mat2_mul_trunc.sv
// Combinational 2x2 matrix multiply, every product and sum truncated to W bits.
module mat2_mul_trunc #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a00_i,
  input  logic [W-1:0] a01_i,
  input  logic [W-1:0] a10_i,
  input  logic [W-1:0] a11_i,
  input  logic [W-1:0] b00_i,
  input  logic [W-1:0] b01_i,
  input  logic [W-1:0] b10_i,
  input  logic [W-1:0] b11_i,
  output logic [W-1:0] c00_o,
  output logic [W-1:0] c01_o,
  output logic [W-1:0] c10_o,
  output logic [W-1:0] c11_o
);

  // W-bit operands keep every intermediate at W bits, so wrap is implicit.
  assign c00_o = a00_i * b00_i + a01_i * b10_i;
  assign c01_o = a00_i * b01_i + a01_i * b11_i;
  assign c10_o = a10_i * b00_i + a11_i * b10_i;
  assign c11_o = a10_i * b01_i + a11_i * b11_i;

endmodule

// File: rtl/matpow_recur_seq.sv
// Two-term linear recurrence x(n) via 2x2 matrix fast exponentiation,
// one exponent bit per cycle behind a start/done handshake.
module matpow_recur_seq
  import matpow_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic [W-1:0]  coef_a,
  input  logic [W-1:0]  coef_b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result
);

  state_e        state_q;
  logic [NW-1:0] e_q;
  logic [W-1:0]  r00_q, r01_q, r10_q, r11_q;
  logic [W-1:0]  p00_q, p01_q, p10_q, p11_q;
  logic [W-1:0]  rp00_c, rp01_c, rp10_c, rp11_c;
  logic [W-1:0]  pp00_c, pp01_c, pp10_c, pp11_c;

  // R*P: accumulate the current power into the running result.
  mat2_mul_trunc #(.W(W)) u_mul_rp (
    .a00_i(r00_q), .a01_i(r01_q), .a10_i(r10_q), .a11_i(r11_q),
    .b00_i(p00_q), .b01_i(p01_q), .b10_i(p10_q), .b11_i(p11_q),
    .c00_o(rp00_c), .c01_o(rp01_c), .c10_o(rp10_c), .c11_o(rp11_c)
  );

  // P*P: square the power for the next exponent bit.
  mat2_mul_trunc #(.W(W)) u_mul_pp (
    .a00_i(p00_q), .a01_i(p01_q), .a10_i(p10_q), .a11_i(p11_q),
    .b00_i(p00_q), .b01_i(p01_q), .b10_i(p10_q), .b11_i(p11_q),
    .c00_o(pp00_c), .c01_o(pp01_c), .c10_o(pp10_c), .c11_o(pp11_c)
  );

  // Control FSM plus R/P/e/result registers; R and P update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      e_q     <= '0;
      r00_q   <= '0;
      r01_q   <= '0;
      r10_q   <= '0;
      r11_q   <= '0;
      p00_q   <= '0;
      p01_q   <= '0;
      p10_q   <= '0;
      p11_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            r00_q   <= W'(ident_bit(1'b0, 1'b0));
            r01_q   <= W'(ident_bit(1'b0, 1'b1));
            r10_q   <= W'(ident_bit(1'b1, 1'b0));
            r11_q   <= W'(ident_bit(1'b1, 1'b1));
            p00_q   <= coef_a;
            p01_q   <= coef_b;
            p10_q   <= W'(1);
            p11_q   <= '0;
            e_q     <= n;
            busy    <= 1'b1;
            state_q <= ST_LOOP;
          end
        end
        ST_LOOP: begin
          if (e_q != '0) begin
            if (e_q[0]) begin
              r00_q <= rp00_c;
              r01_q <= rp01_c;
              r10_q <= rp10_c;
              r11_q <= rp11_c;
            end
            p00_q <= pp00_c;
            p01_q <= pp01_c;
            p10_q <= pp10_c;
            p11_q <= pp11_c;
            e_q   <= e_q >> 1;
          end else begin
            result  <= r10_q;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matpow_recur_seq.sv
// Directed self-checking bench for matpow_recur_seq (W=32, NW=32).
module tb_matpow_recur_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] n;
  logic [31:0] coef_a;
  logic [31:0] coef_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_miss = 0;

  int lat_obs;
  int busy_cyc;
  int done_cnt;

  matpow_recur_seq #(.W(32), .NW(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .n      (n),
    .coef_a (coef_a),
    .coef_b (coef_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Accept one request, scramble inputs afterwards, wait (bounded) for done.
  task automatic launch(input logic [31:0] nv, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start  = 1'b1;
    n      = nv;
    coef_a = av;
    coef_b = bv;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n      = 32'hDEAD_BEEF;
    coef_a = 32'd7;
    coef_b = 32'd5;
  endtask

  task automatic wait_done();
    lat_obs  = 0;
    busy_cyc = 0;
    while (!done && lat_obs < 100) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat_obs++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] nv, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res, input int exp_lat);
    launch(nv, av, bv);
    chk({tag, "_busy_on_accept"}, 64'(busy), 64'd1);
    wait_done();
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_latency"}, 64'(lat_obs), 64'(exp_lat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_drops"}, 64'(done), 64'd0);
    chk({tag, "_result_holds"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    n      = '0;
    coef_a = '0;
    coef_b = '0;
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fibonacci
    run_op("fib0", 32'd0, 32'd1, 32'd1, 32'd0, 1);
    run_op("fib1", 32'd1, 32'd1, 32'd1, 32'd1, 2);
    run_op("fib10", 32'd10, 32'd1, 32'd1, 32'd55, 5);
    // Width boundary
    run_op("fib47", 32'd47, 32'd1, 32'd1, 32'd2971215073, 7);
    run_op("fib48", 32'd48, 32'd1, 32'd1, 32'd512559680, 7);
    // Generalised coefficients
    run_op("pell5", 32'd5, 32'd2, 32'd1, 32'd29, 4);
    run_op("geo3_4", 32'd4, 32'd3, 32'd0, 32'd27, 4);

    // start held during busy is ignored
    launch(32'd10, 32'd1, 32'd1);
    start    = 1'b1;
    n        = 32'd3;
    coef_a   = 32'd1;
    coef_b   = 32'd1;
    done_cnt = 0;
    lat_obs  = 0;
    while (!done && lat_obs < 100) begin
      @(posedge clk);
      #1;
      lat_obs++;
    end
    start = 1'b0;
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_result", 64'(result), 64'd55);
    chk("hold_latency", 64'(lat_obs), 64'd5);
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("hold_no_extra_done", 64'(done_cnt), 64'd0);
    chk("hold_idle", 64'(busy), 64'd0);

    // start in the done cycle is accepted
    launch(32'd10, 32'd1, 32'd1);
    wait_done();
    chk("b2b_first_done", 64'(done), 64'd1);
    chk("b2b_first_result", 64'(result), 64'd55);
    start  = 1'b1;
    n      = 32'd3;
    coef_a = 32'd1;
    coef_b = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accepted_busy", 64'(busy), 64'd1);
    wait_done();
    chk("b2b_second_done", 64'(done), 64'd1);
    chk("b2b_second_result", 64'(result), 64'd2);
    chk("b2b_second_latency", 64'(lat_obs), 64'd3);

    // Maximum exponent: latency NW+1, busy for the same span
    launch(32'hFFFF_FFFF, 32'd1, 32'd1);
    wait_done();
    chk("max_done", 64'(done), 64'd1);
    chk("max_latency", 64'(lat_obs), 64'd33);
    chk("max_busy_cycles", 64'(busy_cyc), 64'd33);

    // Reset mid-LOOP drops everything and loses the request
    launch(32'd1000, 32'd1, 32'd1);
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done || busy) done_cnt++;
    end
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    run_op("post_rst_fib6", 32'd6, 32'd1, 32'd1, 32'd8, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule
